// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt arbiter: bridge register map,
// CTRL bit positions and the request/service FSM encoding.
package irq_pkg;

  localparam logic [1:0] ADDR_CTRL = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_PEND = 2'd2;
  localparam logic [1:0] ADDR_VEC  = 2'd3;

  localparam int CTRL_GEN_BIT = 8;
  localparam int VEC_VALID_BIT = 31;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_INSVC = 2'd2
  } state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational priority encoder: reports the lowest set index of req_i,
// which is the highest-priority interrupt source.
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int N_SRC = 6,
  parameter int ID_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic [N_SRC-1:0] req_i,
  output logic [ID_W-1:0]  id_o,
  output logic             valid_o
);

  always_comb begin
    // NOTE: every output gets a default before any conditional assignment,
    // otherwise synthesis infers a latch to hold the old value.
    id_o    = '0;
    valid_o = 1'b0;
    // Scanning downwards lets the lowest set index be the last writer.
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        id_o    = ID_W'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_arbiter.sv
// Interrupt arbiter between device sources and CP0: latches requests,
// applies mask/enable and sequences request -> acknowledge -> EOI.
module irq_arbiter
  import irq_pkg::*;
#(
  parameter int N_SRC = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             we,
  input  logic [1:0]       addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic [N_SRC-1:0] hwint,
  input  logic             int_ack
);

  localparam int ID_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  state_e           state_q, state_d;
  logic [N_SRC-1:0] edge_mode_q, edge_mode_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] src_q;
  logic             gen_q, gen_d;
  logic [ID_W-1:0]  cur_id_q, cur_id_d;

  logic [ID_W-1:0]  sel_id;
  logic             sel_valid;
  logic [N_SRC-1:0] active, cur_onehot, edge_set, w1c_clr, ack_clr;
  logic             wr_ctrl, wr_mask, wr_pend, wr_vec, take_ack;
  logic             unused_wdata;

  assign wr_ctrl = we && (addr == ADDR_CTRL);
  assign wr_mask = we && (addr == ADDR_MASK);
  assign wr_pend = we && (addr == ADDR_PEND);
  assign wr_vec  = we && (addr == ADDR_VEC);

  // Bits with no register behind them are write-ignored.
  assign unused_wdata = ^{wdata[31:CTRL_GEN_BIT+1], wdata[CTRL_GEN_BIT-1:N_SRC]};

  assign active     = pend_q & mask_q & {N_SRC{gen_q}};
  assign cur_onehot = N_SRC'(1) << cur_id_q;

  irq_prio_enc #(
    .N_SRC (N_SRC),
    .ID_W  (ID_W)
  ) u_prio_enc (
    .req_i   (active),
    .id_o    (sel_id),
    .valid_o (sel_valid)
  );

  always_comb begin
    state_d  = state_q;
    cur_id_d = cur_id_q;
    take_ack = 1'b0;
    hwint    = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (sel_valid) begin
          state_d  = ST_REQ;
          cur_id_d = sel_id;
        end
      end
      ST_REQ: begin
        hwint = cur_onehot;
        // A withdrawn request cancels the presentation, even against an ack.
        if (!active[cur_id_q]) begin
          state_d = ST_IDLE;
        end else if (int_ack) begin
          state_d  = ST_INSVC;
          take_ack = 1'b1;
        end
      end
      ST_INSVC: begin
        if (wr_vec) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Edge sources: a new edge beats any same-cycle clear; level sources track the pin.
  assign edge_set = edge_mode_q & irq_src & ~src_q;
  assign w1c_clr  = wr_pend  ? (wdata[N_SRC-1:0] & edge_mode_q) : '0;
  assign ack_clr  = take_ack ? (cur_onehot & edge_mode_q) : '0;
  assign pend_d   = (edge_mode_q & ((pend_q & ~w1c_clr & ~ack_clr) | edge_set))
                  | (~edge_mode_q & irq_src);

  assign edge_mode_d = wr_ctrl ? wdata[N_SRC-1:0] : edge_mode_q;
  assign gen_d       = wr_ctrl ? wdata[CTRL_GEN_BIT] : gen_q;
  assign mask_d      = wr_mask ? wdata[N_SRC-1:0] : mask_q;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      state_q     <= ST_IDLE;
      edge_mode_q <= '0;
      gen_q       <= 1'b0;
      mask_q      <= '0;
      pend_q      <= '0;
      src_q       <= '0;
      cur_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      edge_mode_q <= edge_mode_d;
      gen_q       <= gen_d;
      mask_q      <= mask_d;
      pend_q      <= pend_d;
      src_q       <= irq_src;
      cur_id_q    <= cur_id_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      ADDR_CTRL: begin
        rdata[N_SRC-1:0]    = edge_mode_q;
        rdata[CTRL_GEN_BIT] = gen_q;
      end
      ADDR_MASK: rdata[N_SRC-1:0] = mask_q;
      ADDR_PEND: rdata[N_SRC-1:0] = pend_q;
      default: begin
        rdata[VEC_VALID_BIT] = (state_q != ST_IDLE);
        rdata[ID_W-1:0]      = cur_id_q;
      end
    endcase
  end

endmodule

// File: tb/tb_irq_arbiter.sv
// Self-checking bench for irq_arbiter: directed scenarios with literal
// expectations plus a randomized run against a behavioural model.
module tb_irq_arbiter;
  import irq_pkg::*;

  localparam int N = 6;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] irq_src = '0;
  logic         we = 1'b0;
  logic [1:0]   addr = '0;
  logic [31:0]  wdata = '0;
  logic [31:0]  rdata;
  logic [N-1:0] hwint;
  logic         int_ack = 1'b0;

  irq_arbiter #(.N_SRC(N)) dut (
    .clk     (clk),
    .reset   (reset),
    .irq_src (irq_src),
    .we      (we),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .hwint   (hwint),
    .int_ack (int_ack)
  );

  always #10 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model. phase: 0 = nothing presented, 1 = presenting m_cur
  // to CP0, 2 = CP0 servicing m_cur until EOI.
  bit m_edge[N], m_mask[N], m_pend[N], m_srcq[N];
  bit m_gen;
  int m_phase = 0;
  int m_cur = 0;

  always @(posedge clk) begin : model_step
    bit act[N];
    bit nxt[N];
    int sel;
    int clr;
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        m_edge[i] = 0; m_mask[i] = 0; m_pend[i] = 0; m_srcq[i] = 0;
      end
      m_gen = 0; m_phase = 0; m_cur = 0;
    end else begin
      sel = -1;
      for (int i = N - 1; i >= 0; i--) begin
        act[i] = m_pend[i] && m_mask[i] && m_gen;
        if (act[i]) sel = i;
      end
      clr = -1;
      case (m_phase)
        0: if (sel >= 0) begin m_phase = 1; m_cur = sel; end
        1: if (!act[m_cur]) m_phase = 0;
           else if (int_ack) begin m_phase = 2; clr = m_cur; end
        default: if (we && addr == 2'd3) m_phase = 0;
      endcase
      for (int i = 0; i < N; i++) begin
        if (m_edge[i])
          nxt[i] = (m_pend[i] && !(we && addr == 2'd2 && wdata[i]) && i != clr)
                   || (irq_src[i] && !m_srcq[i]);
        else
          nxt[i] = irq_src[i];
      end
      for (int i = 0; i < N; i++) begin
        m_pend[i] = nxt[i];
        m_srcq[i] = irq_src[i];
      end
      if (we && addr == 2'd0) begin
        for (int i = 0; i < N; i++) m_edge[i] = wdata[i];
        m_gen = wdata[8];
      end
      if (we && addr == 2'd1)
        for (int i = 0; i < N; i++) m_mask[i] = wdata[i];
    end
  end

  function automatic logic [31:0] m_read(input logic [1:0] a);
    logic [31:0] r = '0;
    case (a)
      2'd0: begin
        for (int i = 0; i < N; i++) r[i] = m_edge[i];
        r[8] = m_gen;
      end
      2'd1: for (int i = 0; i < N; i++) r[i] = m_mask[i];
      2'd2: for (int i = 0; i < N; i++) r[i] = m_pend[i];
      default: begin
        r[31]  = (m_phase != 0);
        r[4:0] = m_cur[4:0];
      end
    endcase
    return r;
  endfunction

  function automatic logic [N-1:0] m_hwint();
    logic [N-1:0] h = '0;
    if (m_phase == 1) h[m_cur] = 1'b1;
    return h;
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_hwint", 32'(hwint), 32'(m_hwint()));
      check("model_rdata", rdata, m_read(addr));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    cyc();
    we    = 1'b0;
  endtask

  task automatic ack();
    int_ack = 1'b1;
    cyc();
    int_ack = 1'b0;
  endtask

  initial begin
    logic [31:0] d;

    cyc(); cyc();
    cmp_en = 1'b1;
    check("rst_hwint", 32'(hwint), 32'h0);
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d);
      check("rst_reg", d, 32'h0);
    end
    reset = 1'b0;
    cyc();

    // Single edge source through request, ack and EOI.
    wr(ADDR_CTRL, 32'h101);
    wr(ADDR_MASK, 32'h01);
    irq_src = 6'b000001; cyc(); irq_src = '0;
    check("t1_hwint_early", 32'(hwint), 32'h0);
    rd(ADDR_PEND, d); check("t1_pend", d, 32'h1);
    cyc();
    check("t1_hwint", 32'(hwint), 32'h01);
    rd(ADDR_VEC, d); check("t1_vec_req", d, 32'h8000_0000);
    ack();
    check("t1_hwint_ack", 32'(hwint), 32'h0);
    rd(ADDR_PEND, d); check("t1_pend_ack", d, 32'h0);
    wr(ADDR_VEC, 32'h0);
    rd(ADDR_VEC, d); check("t1_vec_eoi", d, 32'h0);

    // Level sources 3 and 1 together: 1 wins, 3 follows after EOI.
    wr(ADDR_CTRL, 32'h100);
    wr(ADDR_MASK, 32'h3F);
    irq_src = 6'b001010; cyc(); cyc();
    check("t2_hwint1", 32'(hwint), 32'h02);
    rd(ADDR_VEC, d); check("t2_vec1", d, 32'h8000_0001);
    ack();
    irq_src = 6'b001000; cyc();
    wr(ADDR_VEC, 32'h0);
    cyc();
    check("t2_hwint3", 32'(hwint), 32'h08);
    rd(ADDR_VEC, d); check("t2_vec3", d, 32'h8000_0003);
    ack();
    irq_src = '0;
    wr(ADDR_VEC, 32'h0);
    cyc();

    // Masking the presented source withdraws the request.
    irq_src = 6'b000100; cyc(); cyc();
    check("t3_hwint", 32'(hwint), 32'h04);
    wr(ADDR_MASK, 32'h0);
    cyc();
    check("t3_hwint_drop", 32'(hwint), 32'h0);
    rd(ADDR_VEC, d); check("t3_idle", 32'(d[31]), 32'h0);
    ack();
    check("t3_ack_ignored", 32'(hwint), 32'h0);
    rd(ADDR_VEC, d); check("t3_ack_idle", 32'(d[31]), 32'h0);
    irq_src = '0; cyc();

    // Edge set beats write-1-to-clear in the same cycle.
    wr(ADDR_CTRL, 32'h110);
    irq_src = 6'b010000; cyc(); irq_src = '0; cyc();
    rd(ADDR_PEND, d); check("t4_pend_set", d, 32'h10);
    irq_src = 6'b010000;
    wr(ADDR_PEND, 32'h10);
    rd(ADDR_PEND, d); check("t4_set_wins", d, 32'h10);
    wr(ADDR_PEND, 32'h10);
    rd(ADDR_PEND, d); check("t4_w1c", d, 32'h0);
    irq_src = '0; cyc();

    // Reset in the middle of service.
    wr(ADDR_CTRL, 32'h121);
    wr(ADDR_MASK, 32'h21);
    irq_src = 6'b100001; cyc(); irq_src = '0; cyc();
    check("t5_hwint", 32'(hwint), 32'h01);
    ack();
    irq_src = 6'b000001; cyc(); irq_src = '0;
    rd(ADDR_PEND, d); check("t5_pend", d, 32'h21);
    rd(ADDR_VEC, d); check("t5_vec", d, 32'h8000_0000);
    reset = 1'b1; cyc();
    check("t5_rst_hwint", 32'(hwint), 32'h0);
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d);
      check("t5_rst_reg", d, 32'h0);
    end
    reset = 1'b0; cyc();

    // No nesting: a new source during service waits for EOI.
    wr(ADDR_CTRL, 32'h101);
    wr(ADDR_MASK, 32'h01);
    irq_src = 6'b000001; cyc(); irq_src = '0; cyc();
    ack();
    irq_src = 6'b000001; cyc(); irq_src = '0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("t6_no_nest", 32'(hwint), 32'h0);
    end
    wr(ADDR_VEC, 32'h0);
    check("t6_eoi_plus1", 32'(hwint), 32'h0);
    cyc();
    check("t6_eoi_plus2", 32'(hwint), 32'h01);

    // Randomized traffic, checked every cycle against the model.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 3) == 0) irq_src = N'($urandom);
      addr    = 2'($urandom);
      wdata   = $urandom;
      we      = ($urandom_range(0, 5) == 0);
      if (addr == ADDR_CTRL) wdata[8] = ($urandom_range(0, 3) != 0);
      int_ack = ($urandom_range(0, 3) == 0);
      reset   = ($urandom_range(0, 499) == 0);
      cyc();
    end
    we = 1'b0; int_ack = 1'b0; reset = 1'b0;
    cyc(); cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
